// File: rtl/umi_req_arbiter_if.sv
// umi_req_arbiter_if: requester-side and host-side UMI request/response bundle for umi_req_arbiter
interface umi_req_arbiter_if #(
  parameter int N = 2,
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 64,
  parameter int DEPTH = 4
);
  localparam int OW = $clog2(DEPTH) + 1;
  logic [N-1:0] req_valid;
  logic [N*CW-1:0] req_cmd;
  logic [N*AW-1:0] req_dstaddr;
  logic [N*AW-1:0] req_srcaddr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0] req_ready;
  logic [N-1:0] resp_valid;
  logic [CW-1:0] resp_cmd;
  logic [AW-1:0] resp_dstaddr;
  logic [AW-1:0] resp_srcaddr;
  logic [DW-1:0] resp_data;
  logic [N-1:0] resp_ready;
  logic uhost_req_valid;
  logic [CW-1:0] uhost_req_cmd;
  logic [AW-1:0] uhost_req_dstaddr;
  logic [AW-1:0] uhost_req_srcaddr;
  logic [DW-1:0] uhost_req_data;
  logic uhost_req_ready;
  logic uhost_resp_valid;
  logic [CW-1:0] uhost_resp_cmd;
  logic [AW-1:0] uhost_resp_dstaddr;
  logic [AW-1:0] uhost_resp_srcaddr;
  logic [DW-1:0] uhost_resp_data;
  logic uhost_resp_ready;
  logic [OW-1:0] outstanding;
  logic resp_orphan;
  modport master (
    input req_valid, req_cmd, req_dstaddr, req_srcaddr, req_data, resp_ready,
    input uhost_req_ready, uhost_resp_valid, uhost_resp_cmd, uhost_resp_dstaddr, uhost_resp_srcaddr, uhost_resp_data,
    output req_ready, resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data,
    output uhost_req_valid, uhost_req_cmd, uhost_req_dstaddr, uhost_req_srcaddr, uhost_req_data, uhost_resp_ready,
    output outstanding, resp_orphan
  );
  modport slave (
    output req_valid, req_cmd, req_dstaddr, req_srcaddr, req_data, resp_ready,
    output uhost_req_ready, uhost_resp_valid, uhost_resp_cmd, uhost_resp_dstaddr, uhost_resp_srcaddr, uhost_resp_data,
    input req_ready, resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data,
    input uhost_req_valid, uhost_req_cmd, uhost_req_dstaddr, uhost_req_srcaddr, uhost_req_data, uhost_resp_ready,
    input outstanding, resp_orphan
  );
endinterface

// File: rtl/umi_req_arbiter.sv
// umi_req_arbiter: packet-locked N:1 UMI request arbiter with in-order response steering (UMI_ARB_FIXED_PRIO_EN selects fixed priority)
module umi_req_arbiter #(
  parameter int N = 2,
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 64,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  umi_req_arbiter_if.master bus
);
  localparam int IW = $clog2(N);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0] state;
  logic [IW-1:0] owner, win, head;
  logic [IW-1:0] fifo [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] count;
  logic orphan, busy, req_hs, eom_hs, push, pop, empty, full, resp_hs;
  logic [4:0] opcode;
  logic [N-1:0][CW-1:0] cmd_a;
  logic [N-1:0][AW-1:0] dst_a, src_a;
  logic [N-1:0][DW-1:0] data_a;
  assign cmd_a = bus.req_cmd;
  assign dst_a = bus.req_dstaddr;
  assign src_a = bus.req_srcaddr;
  assign data_a = bus.req_data;
  assign busy = state == BUSY;
  assign bus.uhost_req_valid = busy & bus.req_valid[owner];
  assign bus.uhost_req_cmd = cmd_a[owner];
  assign bus.uhost_req_dstaddr = dst_a[owner];
  assign bus.uhost_req_srcaddr = src_a[owner];
  assign bus.uhost_req_data = data_a[owner];
  assign bus.req_ready = busy ? N'(bus.uhost_req_ready) << owner : '0;
  assign req_hs = bus.uhost_req_valid & bus.uhost_req_ready;
  assign eom_hs = req_hs & bus.uhost_req_cmd[22];
  assign opcode = bus.uhost_req_cmd[4:0];
  assign push = eom_hs & opcode[0] & (opcode != 5'h05);
  assign empty = count == '0;
  assign full = count[PW];
  assign head = fifo[rd_ptr];
  assign bus.resp_valid = empty ? '0 : N'(bus.uhost_resp_valid) << head;
  assign bus.uhost_resp_ready = empty | bus.resp_ready[head];
  assign resp_hs = bus.uhost_resp_valid & bus.uhost_resp_ready;
  assign pop = resp_hs & ~empty & bus.uhost_resp_cmd[22];
  assign bus.resp_cmd = bus.uhost_resp_cmd;
  assign bus.resp_dstaddr = bus.uhost_resp_dstaddr;
  assign bus.resp_srcaddr = bus.uhost_resp_srcaddr;
  assign bus.resp_data = bus.uhost_resp_data;
  assign bus.outstanding = count;
  assign bus.resp_orphan = orphan;
`ifdef UMI_ARB_FIXED_PRIO_EN
  // lowest-index valid requester wins
  always_comb begin
    win = '0;
    for (int i = N - 1; i >= 0; i--) if (bus.req_valid[i]) win = IW'(i);
  end
`else
  logic [IW-1:0] ptr, idx;
  // first valid requester after the last owner wins; scanning far-to-near lets the nearest overwrite
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (bus.req_valid[idx]) win = idx;
    end
  end
  // remember the owner of the last completed packet so it goes to the back of the line
  always_ff @(posedge clk)
    if (reset) ptr <= IW'(N - 1);
    else if (eom_hs) ptr <= owner;
`endif
  // packet lock: grant only when idle and a response slot is free, release on the eom beat
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      owner <= '0;
    end else if (!busy) begin
      if (|bus.req_valid && !full) begin
        state <= BUSY;
        owner <= win;
      end
    end else if (eom_hs) state <= IDLE;
  // owner FIFO storage, not reset since count and pointers qualify it
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= owner;
  // owner FIFO pointers and occupancy
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + OW'(push) - OW'(pop);
    end
  // sticky flag for responses that no requester was waiting for
  always_ff @(posedge clk)
    if (reset) orphan <= 1'b0;
    else if (resp_hs && empty) orphan <= 1'b1;
endmodule

// File: tb/tb_umi_req_arbiter.sv
// tb_umi_req_arbiter: directed vectors for umi_req_arbiter in the default round-robin build
module tb_umi_req_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  umi_req_arbiter_if #(.N(2), .CW(32), .AW(64), .DW(64), .DEPTH(4)) bus ();
  umi_req_arbiter #(.N(2), .CW(32), .AW(64), .DW(64), .DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mk(input logic [4:0] op, input logic eom);
    return {9'b0, eom, 17'b0, op};
  endfunction
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic set_req(input logic i, input logic v, input logic [4:0] op, input logic e, input logic [63:0] a);
    bus.req_valid[i] = v;
    bus.req_cmd[{i, 5'b0} +: 32] = mk(op, e);
    bus.req_dstaddr[{i, 6'b0} +: 64] = a;
    bus.req_srcaddr[{i, 6'b0} +: 64] = a;
    bus.req_data[{i, 6'b0} +: 64] = ~a;
  endtask
  task automatic resp(input logic v, input logic [4:0] op, input logic e);
    bus.uhost_resp_valid = v;
    bus.uhost_resp_cmd = mk(op, e);
    bus.uhost_resp_dstaddr = 64'h55;
    bus.uhost_resp_srcaddr = 64'h66;
    bus.uhost_resp_data = 64'hd00d;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    bus.uhost_resp_valid = 1'b0;
    bus.uhost_req_ready = 1'b1;
    bus.resp_ready = 2'b11;
    cyc(2);
    reset = 1'b0;
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_cmd = '0;
    bus.req_dstaddr = '0;
    bus.req_srcaddr = '0;
    bus.req_data = '0;
    bus.resp_ready = 2'b11;
    bus.uhost_req_ready = 1'b1;
    resp(1'b0, 5'h0, 1'b0);
    do_reset();
    #1;
    chk("rst_req_valid", bus.uhost_req_valid, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_outstanding", bus.outstanding, 0);
    chk("rst_orphan", bus.resp_orphan, 0);
    chk("rst_resp_ready", bus.uhost_resp_ready, 1);
    set_req(1'b0, 1'b1, 5'h01, 1'b1, 64'h100);
    #1;
    chk("rd_bubble", bus.uhost_req_valid, 0);
    cyc();
    #1;
    chk("rd_valid", bus.uhost_req_valid, 1);
    chk("rd_dst", bus.uhost_req_dstaddr, 64'h100);
    chk("rd_data", bus.uhost_req_data, ~64'h100);
    chk("rd_ready", bus.req_ready, 2'b01);
    cyc();
    set_req(1'b0, 1'b0, 5'h01, 1'b1, 64'h100);
    #1;
    chk("rd_outst", bus.outstanding, 1);
    chk("rd_idle", bus.uhost_req_valid, 0);
    resp(1'b1, 5'h02, 1'b1);
    #1;
    chk("rd_resp_valid", bus.resp_valid, 2'b01);
    chk("rd_resp_data", bus.resp_data, 64'hd00d);
    chk("rd_resp_ready", bus.uhost_resp_ready, 1);
    cyc();
    resp(1'b0, 5'h02, 1'b1);
    #1;
    chk("rd_outst_done", bus.outstanding, 0);
    chk("rd_resp_idle", bus.resp_valid, 0);
    set_req(1'b0, 1'b1, 5'h05, 1'b1, 64'h200);
    cyc();
    #1;
    chk("pw_valid", bus.uhost_req_valid, 1);
    chk("pw_cmd", bus.uhost_req_cmd, mk(5'h05, 1'b1));
    cyc();
    set_req(1'b0, 1'b0, 5'h05, 1'b1, 64'h200);
    #1;
    chk("pw_outst", bus.outstanding, 0);
    do_reset();
    set_req(1'b0, 1'b1, 5'h03, 1'b1, 64'h0);
    set_req(1'b1, 1'b1, 5'h03, 1'b1, 64'h1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1;
      chk($sformatf("alt_valid%0d", k), bus.uhost_req_valid, 1);
      chk($sformatf("alt_dst%0d", k), bus.uhost_req_dstaddr, 64'(k % 2));
      cyc();
      #1;
      chk($sformatf("alt_bubble%0d", k), bus.uhost_req_valid, 0);
    end
    chk("alt_outst", bus.outstanding, 4);
    cyc(2);
    #1;
    chk("full_stall", bus.uhost_req_valid, 0);
    chk("full_outst", bus.outstanding, 4);
    resp(1'b1, 5'h02, 1'b1);
    #1;
    chk("full_resp_head0", bus.resp_valid, 2'b01);
    cyc();
    resp(1'b0, 5'h02, 1'b1);
    #1;
    chk("pop_outst", bus.outstanding, 3);
    chk("pop_no_grant", bus.uhost_req_valid, 0);
    cyc();
    #1;
    chk("fifth_valid", bus.uhost_req_valid, 1);
    chk("fifth_dst", bus.uhost_req_dstaddr, 64'h0);
    bus.resp_ready = 2'b01;
    resp(1'b1, 5'h02, 1'b1);
    #1;
    chk("head1_resp_valid", bus.resp_valid, 2'b10);
    chk("head1_backpressure", bus.uhost_resp_ready, 0);
    do_reset();
    #1;
    chk("flush_outst", bus.outstanding, 0);
    chk("flush_resp_valid", bus.resp_valid, 0);
    set_req(1'b1, 1'b1, 5'h03, 1'b0, 64'h11);
    cyc();
    bus.uhost_req_ready = 1'b0;
    set_req(1'b0, 1'b1, 5'h01, 1'b1, 64'h0);
    #1;
    chk("mb_b1_dst", bus.uhost_req_dstaddr, 64'h11);
    chk("mb_b1_stall", bus.req_ready, 2'b00);
    cyc();
    bus.uhost_req_ready = 1'b1;
    #1;
    chk("mb_b1_dst_hold", bus.uhost_req_dstaddr, 64'h11);
    chk("mb_b1_ready", bus.req_ready, 2'b10);
    cyc();
    set_req(1'b1, 1'b1, 5'h03, 1'b0, 64'h12);
    bus.uhost_req_ready = 1'b0;
    #1;
    chk("mb_b2_dst", bus.uhost_req_dstaddr, 64'h12);
    cyc();
    bus.uhost_req_ready = 1'b1;
    #1;
    chk("mb_b2_ready", bus.req_ready, 2'b10);
    cyc();
    set_req(1'b1, 1'b1, 5'h03, 1'b1, 64'h13);
    #1;
    chk("mb_b3_dst", bus.uhost_req_dstaddr, 64'h13);
    cyc();
    set_req(1'b1, 1'b0, 5'h03, 1'b1, 64'h13);
    #1;
    chk("mb_bubble", bus.uhost_req_valid, 0);
    chk("mb_bubble_ready", bus.req_ready, 2'b00);
    cyc();
    #1;
    chk("mb_req0_valid", bus.uhost_req_valid, 1);
    chk("mb_req0_dst", bus.uhost_req_dstaddr, 64'h0);
    chk("mb_req0_ready", bus.req_ready, 2'b01);
    cyc();
    set_req(1'b0, 1'b0, 5'h01, 1'b1, 64'h0);
    #1;
    chk("mb_outst", bus.outstanding, 2);
    do_reset();
    resp(1'b1, 5'h02, 1'b1);
    #1;
    chk("orph_resp_ready", bus.uhost_resp_ready, 1);
    chk("orph_resp_valid", bus.resp_valid, 0);
    chk("orph_pre", bus.resp_orphan, 0);
    cyc();
    resp(1'b0, 5'h02, 1'b1);
    #1;
    chk("orph_set", bus.resp_orphan, 1);
    cyc(3);
    #1;
    chk("orph_held", bus.resp_orphan, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("orph_clear", bus.resp_orphan, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
